// File: rtl/id_ex_stage_pkg.sv
//------------------------------------------------------------------------------
// id_ex_stage_pkg
//   Shared widths, ALU control codes and forward-select encoding for ID/EX.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package id_ex_stage_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SHIFT = 4'b0011;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_forward_unit.sv
//------------------------------------------------------------------------------
// forward_unit
//   Picks the forwarding source for both EX operands; EX/MEM beats MEM/WB.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module forward_unit #(
    parameter int REG_ADDR_W = id_ex_stage_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0]     ex_rs1,
    input  logic [REG_ADDR_W-1:0]     ex_rs2,
    input  logic [REG_ADDR_W-1:0]     exmem_rd,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_W-1:0]     memwb_rd,
    input  logic                      memwb_reg_write,
    output id_ex_stage_pkg::fwd_sel_e fwd_a_sel,
    output id_ex_stage_pkg::fwd_sel_e fwd_b_sel
);
    import id_ex_stage_pkg::*;

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    function automatic fwd_sel_e select_src(input logic [REG_ADDR_W-1:0] rs);
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs))
            return FWD_EXMEM;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs))
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

    always_comb begin
        fwd_a_sel = select_src(ex_rs1);
        fwd_b_sel = select_src(ex_rs2);
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
//------------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with operand forwarding and load-use bubble insert.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
    parameter int XLEN       = id_ex_stage_pkg::XLEN,
    parameter int REG_ADDR_W = id_ex_stage_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic                  id_alu_src,
    input  logic [3:0]            id_alu_ctrl,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_branch,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_reg_write,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic                  memwb_reg_write,
    input  logic [XLEN-1:0]       memwb_wdata,
    output logic                  load_use_stall,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_alu_a,
    output logic [XLEN-1:0]       ex_alu_b,
    output logic [3:0]            ex_alu_ctrl,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_branch
);
    import id_ex_stage_pkg::*;

    logic                  r_valid;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_rs1_data;
    logic [XLEN-1:0]       r_rs2_data;
    logic [XLEN-1:0]       r_imm;
    logic                  r_alu_src;
    logic [3:0]            r_alu_ctrl;
    logic                  r_reg_write;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_mem_to_reg;
    logic                  r_branch;

    logic                  w_bubble;
    logic [XLEN-1:0]       w_fwd_rs1;
    logic [XLEN-1:0]       w_fwd_rs2;
    fwd_sel_e              w_fwd_a_sel;
    fwd_sel_e              w_fwd_b_sel;

    // A load in EX cannot supply its data until MEM, so a dependent ID must wait.
    assign load_use_stall = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
                            ((r_rd == id_rs1) || (id_uses_rs2 && (r_rd == id_rs2)));

    // Flush outranks stall; a load-use bubble only lands when not stalled.
    assign w_bubble = !reset_n || flush_in || (!stall_in && load_use_stall);

    always_ff @(posedge clk) begin
        if (w_bubble) begin
            r_valid      <= 1'b0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_alu_src    <= 1'b0;
            r_alu_ctrl   <= ALU_AND;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
        end else if (!stall_in) begin
            r_valid      <= id_valid;
            r_rs1        <= id_rs1;
            r_rs2        <= id_rs2;
            r_rd         <= id_rd;
            r_rs1_data   <= id_rs1_data;
            r_rs2_data   <= id_rs2_data;
            r_imm        <= id_imm;
            r_alu_src    <= id_alu_src;
            r_alu_ctrl   <= id_alu_ctrl;
            r_reg_write  <= id_reg_write  & id_valid;
            r_mem_read   <= id_mem_read   & id_valid;
            r_mem_write  <= id_mem_write  & id_valid;
            r_mem_to_reg <= id_mem_to_reg & id_valid;
            r_branch     <= id_branch     & id_valid;
        end
    end

    forward_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_forward_unit (
        .ex_rs1          (r_rs1),
        .ex_rs2          (r_rs2),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .fwd_a_sel       (w_fwd_a_sel),
        .fwd_b_sel       (w_fwd_b_sel)
    );

    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        case (w_fwd_a_sel)
            FWD_EXMEM: w_fwd_rs1 = exmem_result;
            FWD_MEMWB: w_fwd_rs1 = memwb_wdata;
            default:   w_fwd_rs1 = r_rs1_data;
        endcase
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        case (w_fwd_b_sel)
            FWD_EXMEM: w_fwd_rs2 = exmem_result;
            FWD_MEMWB: w_fwd_rs2 = memwb_wdata;
            default:   w_fwd_rs2 = r_rs2_data;
        endcase
    end

    assign ex_valid      = r_valid;
    assign ex_alu_a      = w_fwd_rs1;
    assign ex_alu_b      = r_alu_src ? r_imm : w_fwd_rs2;
    assign ex_alu_ctrl   = r_alu_ctrl;
    assign ex_store_data = w_fwd_rs2;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_mem_to_reg = r_mem_to_reg;
    assign ex_branch     = r_branch;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//------------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed plus randomized checks of id_ex_stage against a behavioural model.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs2;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alu_src;
    logic [3:0]  id_alu_ctrl;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic        stall_in, flush_in;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [63:0] exmem_result, memwb_wdata;
    logic        load_use_stall, ex_valid;
    logic [63:0] ex_alu_a, ex_alu_b, ex_store_data;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;

    int checks   = 0;
    int failures = 0;

    // Instruction currently expected to sit in EX.
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] d1, d2, imm;
        logic        alu_src;
        logic [3:0]  ctrl;
        logic        rw, mr, mw, m2r, br;
    } ex_t;

    ex_t m = '0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch), .stall_in(stall_in), .flush_in(flush_in),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_result(exmem_result), .memwb_rd(memwb_rd),
        .memwb_reg_write(memwb_reg_write), .memwb_wdata(memwb_wdata),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid),
        .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fwd(input logic [4:0] rs, input logic [63:0] regval);
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs) return exmem_result;
        if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs) return memwb_wdata;
        return regval;
    endfunction

    function automatic logic exp_lus();
        return m.valid && m.mr && m.rd != 5'd0 && id_valid &&
               (m.rd == id_rs1 || (id_uses_rs2 && m.rd == id_rs2));
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".lus"},   64'(load_use_stall), 64'(exp_lus()));
        chk({tag, ".valid"}, 64'(ex_valid), 64'(m.valid));
        chk({tag, ".a"},     ex_alu_a, fwd(m.rs1, m.d1));
        chk({tag, ".b"},     ex_alu_b, m.alu_src ? m.imm : fwd(m.rs2, m.d2));
        chk({tag, ".st"},    ex_store_data, fwd(m.rs2, m.d2));
        chk({tag, ".ctrl"},  64'(ex_alu_ctrl), 64'(m.ctrl));
        chk({tag, ".rd"},    64'(ex_rd), 64'(m.rd));
        chk({tag, ".cbits"},
            64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}),
            64'({m.rw, m.mr, m.mw, m.m2r, m.br}));
    endtask

    // Predict the register update from the present inputs, then cross the edge.
    task automatic tick();
        ex_t nxt;
        if (!reset_n || flush_in)  nxt = '0;
        else if (stall_in)         nxt = m;
        else if (exp_lus())        nxt = '0;
        else begin
            nxt.valid = id_valid;   nxt.rs1 = id_rs1;       nxt.rs2 = id_rs2;
            nxt.rd = id_rd;         nxt.d1 = id_rs1_data;   nxt.d2 = id_rs2_data;
            nxt.imm = id_imm;       nxt.alu_src = id_alu_src; nxt.ctrl = id_alu_ctrl;
            nxt.rw  = id_reg_write  & id_valid;
            nxt.mr  = id_mem_read   & id_valid;
            nxt.mw  = id_mem_write  & id_valid;
            nxt.m2r = id_mem_to_reg & id_valid;
            nxt.br  = id_branch     & id_valid;
        end
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic id_clear();
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_uses_rs2 = 1'b0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_alu_src = 1'b0;
        id_alu_ctrl = 4'b0000; id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_mem_write = 1'b0; id_mem_to_reg = 1'b0; id_branch = 1'b0;
    endtask

    task automatic fwd_clear();
        exmem_rd = '0; exmem_reg_write = 1'b0; exmem_result = '0;
        memwb_rd = '0; memwb_reg_write = 1'b0; memwb_wdata = '0;
    endtask

    initial begin
        id_clear(); fwd_clear();
        stall_in = 1'b0; flush_in = 1'b0;

        // Reset dominates an incoming valid instruction
        reset_n = 1'b0; id_valid = 1'b1; id_reg_write = 1'b1; id_rs1_data = 64'h55;
        tick(); tick();
        check_all("reset");
        chk("reset.valid_c", 64'(ex_valid), 64'd0);
        chk("reset.rw_c",    64'(ex_reg_write), 64'd0);
        chk("reset.ctrl_c",  64'(ex_alu_ctrl), 64'd0);
        chk("reset.a_c",     ex_alu_a, 64'd0);
        reset_n = 1'b1;

        // add x3,x1,x2
        id_clear(); id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs2 = 1'b1;
        id_rs1_data = 64'd5; id_rs2_data = 64'd7; id_alu_ctrl = 4'b0010;
        id_rd = 5'd3; id_reg_write = 1'b1;
        tick();
        check_all("add");
        chk("add.a_c", ex_alu_a, 64'd5);
        chk("add.b_c", ex_alu_b, 64'd7);
        chk("add.rd_c", 64'(ex_rd), 64'd3);
        chk("add.valid_c", 64'(ex_valid), 64'd1);

        // Consumer of x3 with both forward sources competing
        id_rs1 = 5'd3; id_rs2 = 5'd0; id_rs1_data = 64'h111; id_rd = 5'd8;
        tick();
        exmem_rd = 5'd3; exmem_reg_write = 1'b1; exmem_result = 64'd12;
        memwb_rd = 5'd3; memwb_reg_write = 1'b1; memwb_wdata = 64'd99;
        #1; check_all("fwd_both");
        chk("fwd_both.a_c", ex_alu_a, 64'd12);
        exmem_rd = 5'd0;
        #1; chk("fwd_memwb.a_c", ex_alu_a, 64'd99);
        memwb_rd = 5'd0;
        #1; check_all("fwd_x0");
        chk("fwd_x0.a_c", ex_alu_a, 64'h111);
        fwd_clear();

        // ld x5 followed by dependent sub x6,x5,x4
        id_clear(); id_valid = 1'b1; id_rs1 = 5'd1; id_alu_src = 1'b1; id_imm = 64'd8;
        id_alu_ctrl = 4'b0010; id_rd = 5'd5; id_reg_write = 1'b1;
        id_mem_read = 1'b1; id_mem_to_reg = 1'b1;
        tick();
        id_clear(); id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd4; id_uses_rs2 = 1'b1;
        id_alu_ctrl = 4'b0110; id_rd = 5'd6; id_reg_write = 1'b1;
        #1; check_all("lu");
        chk("lu.stall_c", 64'(load_use_stall), 64'd1);
        tick();
        check_all("lu_bubble");
        chk("lu_bubble.valid_c", 64'(ex_valid), 64'd0);
        chk("lu_bubble.rw_c", 64'(ex_reg_write), 64'd0);
        chk("lu_bubble.mr_c", 64'(ex_mem_read), 64'd0);
        tick();
        check_all("lu_resume");

        // rs2 match only matters when rs2 is actually read
        id_clear(); id_valid = 1'b1; id_rs1 = 5'd1; id_rd = 5'd5;
        id_mem_read = 1'b1; id_reg_write = 1'b1;
        tick();
        id_clear(); id_valid = 1'b1; id_rs1 = 5'd4; id_rs2 = 5'd5; id_uses_rs2 = 1'b0;
        #1; chk("lu_norS2.stall_c", 64'(load_use_stall), 64'd0);
        id_uses_rs2 = 1'b1;
        #1; chk("lu_rs2.stall_c", 64'(load_use_stall), 64'd1);

        // Stall holds the register while forwarded data keeps moving
        id_clear(); id_valid = 1'b1; id_rs1 = 5'd7; id_rs1_data = 64'hDEAD;
        id_alu_ctrl = 4'b0110; id_rd = 5'd9; id_reg_write = 1'b1;
        tick();
        stall_in = 1'b1; memwb_rd = 5'd7; memwb_reg_write = 1'b1;
        id_rd = 5'd12; id_alu_ctrl = 4'b0100;
        for (int v = 1; v <= 3; v++) begin
            memwb_wdata = 64'(v);
            tick();
            check_all("stall");
            chk("stall.a_c", ex_alu_a, 64'(v));
            chk("stall.rd_c", 64'(ex_rd), 64'd9);
            chk("stall.ctrl_c", 64'(ex_alu_ctrl), 64'b0110);
        end

        // Flush wins over stall
        flush_in = 1'b1;
        tick();
        check_all("flush");
        chk("flush.valid_c", 64'(ex_valid), 64'd0);
        flush_in = 1'b0; stall_in = 1'b0; fwd_clear();

        // sd x2 with immediate offset and forwarded store data
        id_clear(); id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs2 = 1'b1;
        id_rs2_data = 64'h1111; id_alu_src = 1'b1; id_imm = 64'd16;
        id_alu_ctrl = 4'b0010; id_mem_write = 1'b1;
        tick();
        exmem_rd = 5'd2; exmem_reg_write = 1'b1; exmem_result = 64'hABCD;
        #1; check_all("store");
        chk("store.b_c", ex_alu_b, 64'd16);
        chk("store.st_c", ex_store_data, 64'hABCD);

        // Randomized traffic over a small register window to force collisions
        for (int n = 0; n < 400; n++) begin
            reset_n         = ($urandom_range(0, 39) != 0);
            flush_in        = ($urandom_range(0, 15) == 0);
            stall_in        = ($urandom_range(0, 7) == 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs1          = 5'($urandom_range(0, 7));
            id_rs2          = 5'($urandom_range(0, 7));
            id_rd           = 5'($urandom_range(0, 7));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            id_rs1_data     = {$urandom, $urandom};
            id_rs2_data     = {$urandom, $urandom};
            id_imm          = {$urandom, $urandom};
            id_alu_src      = 1'($urandom_range(0, 1));
            id_alu_ctrl     = 4'($urandom_range(0, 15));
            id_reg_write    = 1'($urandom_range(0, 1));
            id_mem_read     = ($urandom_range(0, 2) == 0);
            id_mem_write    = 1'($urandom_range(0, 1));
            id_mem_to_reg   = 1'($urandom_range(0, 1));
            id_branch       = 1'($urandom_range(0, 1));
            exmem_rd        = 5'($urandom_range(0, 7));
            exmem_reg_write = 1'($urandom_range(0, 1));
            exmem_result    = {$urandom, $urandom};
            memwb_rd        = 5'($urandom_range(0, 7));
            memwb_reg_write = 1'($urandom_range(0, 1));
            memwb_wdata     = {$urandom, $urandom};
            tick();
            check_all("rand");
            exmem_rd = 5'($urandom_range(0, 7));
            memwb_rd = 5'($urandom_range(0, 7));
            #1; check_all("rand_comb");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage of the pipelined core; sits directly upstream of the 64-bit ALU.
- Each cycle it captures one decoded instruction from ID.
- It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, selects the immediate or register for operand B, and drives the ALU's a/b/alu_control_signal inputs.
- It also detects load-use hazards and inserts a bubble.

Parameters:
XLEN, 64, datapath width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2  in  REG_ADDR_W  source register indices
id_uses_rs2  in  1  instruction reads rs2 (R-type/store/branch)
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_alu_src  in  1  1: operand B = imm, 0: operand B = rs2
id_alu_ctrl  in  4  ALU control (0000 and, 0001 or, 0010 add, 0110 sub, 0100 xor, 0011 shift)
id_rd  in  REG_ADDR_W  destination register
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  control bits
stall_in  in  1  downstream stall: hold the register
flush_in  in  1  squash the instruction entering EX
exmem_rd  in  REG_ADDR_W; exmem_reg_write  in  1; exmem_result  in  XLEN  EX/MEM forward source
memwb_rd  in  REG_ADDR_W; memwb_reg_write  in  1; memwb_wdata  in  XLEN  MEM/WB forward source
load_use_stall  out  1  combinational: ID/IF must hold this cycle
ex_valid  out  1  EX holds a real instruction
ex_alu_a, ex_alu_b  out  XLEN  to ALU a/b
ex_alu_ctrl  out  4  to ALU alu_control_signal
ex_store_data  out  XLEN  forwarded rs2 value for stores
ex_rd  out  REG_ADDR_W
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each

Behaviour:
- Reset: synchronous on a rising clk edge with reset_n=0. All registered fields, including ex_valid and the control bits, clear to 0; ex_alu_ctrl = 0000. Reset overrides flush, stall and capture.

Register update, priority highest first:
- flush_in: load a bubble (valid and all control bits 0; data fields don't-care, zeroed).
- stall_in: hold all fields.
- load_use_stall: load a bubble.
- otherwise: capture id_* with ex_valid = id_valid. Control bits are gated by id_valid.

Load-use hazard:
- load_use_stall = ex_valid & ex_mem_read & ex_rd != 0 & id_valid & ((ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
- It is computed purely from the registered EX fields and ID inputs; no flop, no dependency on stall_in.

Forwarding:
- Combinational, applied to the registered rs1/rs2 and data in the same cycle the instruction occupies EX. Added latency is 0 cycles beyond the one register stage.
- Per source s:
  - fwd_s = EXMEM if exmem_reg_write & exmem_rd != 0 & exmem_rd == ex_rs_s;
  - else MEMWB if memwb_reg_write & memwb_rd != 0 & memwb_rd == ex_rs_s;
  - else REG.
- EX/MEM wins when both sources match. x0 is never forwarded.
- ex_alu_a = forwarded rs1.
- ex_store_data = forwarded rs2.
- ex_alu_b = ex_alu_src ? ex_imm : forwarded rs2.

Other rules:
- Forwarded values update while stall_in holds the register, because the sources change underneath. This is required.
- Outputs reflect the register contents even when ex_valid=0; downstream must qualify with ex_valid and the control bits.
- No arithmetic performed; widths pass through unchanged.

Decomposition:
- Shared package: ALU control constants (ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_XOR=0100, ALU_SHIFT=0011), forward-select encoding (FWD_REG=00, FWD_MEMWB=01, FWD_EXMEM=10), XLEN and REG_ADDR_W.
- One sub-module: forward_unit. It is pure combinational select logic per operand and is instantiated once, producing both selects.

Test Plan:
1. reset_n=0 for 2 cycles with id_valid=1, id_reg_write=1 -> ex_valid=0, ex_reg_write=0, ex_alu_ctrl=0000, ex_alu_a=0.
2. ID add x3,x1,x2 (rs1_data=5, rs2_data=7, alu_ctrl=0010), no forwarding -> next cycle ex_alu_a=5, ex_alu_b=7, ex_rd=3, ex_valid=1.
3. EX holds x3 consumer; exmem_rd=3, exmem_reg_write=1, exmem_result=12; memwb_rd=3, memwb_wdata=99 -> ex_alu_a=12 (EX/MEM priority). Repeat with exmem_rd=0, memwb_rd=0 -> register value used.
4. EX has ld x5 (ex_mem_read=1); ID has sub x6,x5,x4 -> load_use_stall=1 same cycle; next cycle ex_valid=0, ex_reg_write=0, ex_mem_read=0. With id_uses_rs2=0 and rs2=x5 -> load_use_stall=0.
5. stall_in=1 for 3 cycles while memwb_wdata changes 1→2→3 on a matching rd -> ex_rd and ex_alu_ctrl constant; ex_alu_a tracks 1, 2, 3.
6. flush_in=1 and stall_in=1 together -> bubble loaded (ex_valid=0). Store sd x2 with alu_src=1, imm=16, exmem forwarding x2=0xABCD -> ex_alu_b=16, ex_store_data=0xABCD.
